// File: rtl/alu_decode_pkg.sv
// Shared ALU definitions: data width, ALU op codes, RV32 opcode/funct constants
// and the command record passed from the decoder to the ALU stage.
`ifndef ALU_DEFINES_SV
`define ALU_DEFINES_SV
`define DATA_WIDTH 32
`endif

package alu_decode_pkg;

  localparam logic [5:0] OP_ALU_ADD  = 6'd0;
  localparam logic [5:0] OP_ALU_SUB  = 6'd1;
  localparam logic [5:0] OP_ALU_SLL  = 6'd2;
  localparam logic [5:0] OP_ALU_SLT  = 6'd3;
  localparam logic [5:0] OP_ALU_SLTU = 6'd4;
  localparam logic [5:0] OP_ALU_XOR  = 6'd5;
  localparam logic [5:0] OP_ALU_SRL  = 6'd6;
  localparam logic [5:0] OP_ALU_SRA  = 6'd7;
  localparam logic [5:0] OP_ALU_OR   = 6'd8;
  localparam logic [5:0] OP_ALU_AND  = 6'd9;
  // Reserved for producers other than the instruction decoder.
  localparam logic [5:0] OP_ALU_INV  = 6'h3f;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [5:0]             op;
    logic [`DATA_WIDTH-1:0] a;
    logic [`DATA_WIDTH-1:0] b;
    logic                   illegal;
  } alu_cmd_t;

  localparam alu_cmd_t CMD_NONE = '{op: OP_ALU_ADD, a: '0, b: '0, illegal: 1'b0};

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational RV32 OP / OP-IMM instruction to ALU command mapping.
// Anything the ALU cannot execute becomes an illegal ADD with zero operands.
module alu_decode_comb
  import alu_decode_pkg::*;
(
  input  logic [31:0]            instr,
  input  logic [`DATA_WIDTH-1:0] rs1_val,
  input  logic [`DATA_WIDTH-1:0] rs2_val,
  output alu_cmd_t               cmd
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op;
  logic       is_imm;
  logic       is_shift;
  logic       legal;
  logic [5:0] op_sel;
  logic       unused_fields;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign is_op    = (opcode == OPC_OP);
  assign is_imm   = (opcode == OPC_OP_IMM);
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

  // rd and rs1 index fields are resolved by the register file, not here.
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    cmd    = '{op: OP_ALU_ADD, a: '0, b: '0, illegal: 1'b1};
    op_sel = OP_ALU_ADD;
    legal  = 1'b0;

    unique case (funct3)
      F3_ADD:  op_sel = OP_ALU_ADD;
      F3_SLL:  op_sel = OP_ALU_SLL;
      F3_SLT:  op_sel = OP_ALU_SLT;
      F3_XOR:  op_sel = OP_ALU_XOR;
      F3_SR:   op_sel = OP_ALU_SRL;
      F3_OR:   op_sel = OP_ALU_OR;
      F3_AND:  op_sel = OP_ALU_AND;
      default: op_sel = OP_ALU_ADD;
    endcase

    // funct7 ALT selects SUB only on register ADD and SRA on either shift-right.
    if (funct7 == FUNCT7_ALT && funct3 == F3_SR)
      op_sel = OP_ALU_SRA;
    if (funct7 == FUNCT7_ALT && funct3 == F3_ADD && is_op)
      op_sel = OP_ALU_SUB;

    if (is_op)
      legal = (funct3 != F3_SLTU) &&
              (funct7 == FUNCT7_ZERO ||
               (funct7 == FUNCT7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)));
    else if (is_imm)
      legal = (funct3 != F3_SLTU) &&
              (!is_shift || funct7 == FUNCT7_ZERO ||
               (funct7 == FUNCT7_ALT && funct3 == F3_SR));

    if (legal) begin
      cmd.op      = op_sel;
      cmd.a       = rs1_val;
      cmd.illegal = 1'b0;
      if (is_op)
        cmd.b = rs2_val;
      else if (is_shift)
        cmd.b = {{(`DATA_WIDTH-5){1'b0}}, instr[24:20]};
      else
        cmd.b = {{(`DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    end
  end

endmodule

// File: rtl/alu_decode.sv
// Decoder stage: two-entry (output register + skid entry) valid/ready buffer
// around alu_decode_comb; in_ready depends only on state and rst.
module alu_decode
  import alu_decode_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [`DATA_WIDTH-1:0] in_rs1_val,
  input  logic [`DATA_WIDTH-1:0] in_rs2_val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             out_alu_op,
  output logic [`DATA_WIDTH-1:0] out_a,
  output logic [`DATA_WIDTH-1:0] out_b,
  output logic                   out_illegal,
  input  logic                   flush
);

  alu_cmd_t dec_cmd;
  alu_cmd_t out_cmd;
  alu_cmd_t skid_cmd;
  logic     skid_valid;
  logic     accept;
  logic     drain;

  alu_decode_comb u_comb (
    .instr   (in_instr),
    .rs1_val (in_rs1_val),
    .rs2_val (in_rs2_val),
    .cmd     (dec_cmd)
  );

  assign in_ready    = !skid_valid && !rst;
  assign accept      = in_valid && in_ready;
  assign drain       = out_valid && out_ready;

  assign out_alu_op  = out_cmd.op;
  assign out_a       = out_cmd.a;
  assign out_b       = out_cmd.b;
  assign out_illegal = out_cmd.illegal;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      // NOTE: the command payloads are reset too, because the outputs must read zero after reset.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_cmd    <= CMD_NONE;
      skid_cmd   <= CMD_NONE;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || drain) begin
      // Output slot is free this edge: skid entry is older, so it goes first.
      if (skid_valid) begin
        out_cmd    <= skid_cmd;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_cmd   <= dec_cmd;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_cmd   <= dec_cmd;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_decode.sv
// Randomized scoreboard bench for alu_decode: stimulus pushes expected commands,
// a negedge monitor compares whatever the DUT presents against the queue head.
module tb_alu_decode;
  import alu_decode_pkg::*;

  localparam int W = `DATA_WIDTH;

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ill;
    bit           chk_c;
    logic [W-1:0] c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_instr;
  logic [W-1:0] in_rs1_val;
  logic [W-1:0] in_rs2_val;
  logic         out_valid;
  logic         out_ready;
  logic [5:0]   out_alu_op;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic         out_illegal;
  logic         flush;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   rand_ready = 1'b0;

  alu_decode dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs1_val  (in_rs1_val),
    .in_rs2_val  (in_rs2_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_op  (out_alu_op),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_illegal (out_illegal),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: what the ALU should compute, by plain arithmetic.
  function automatic logic [W-1:0] alu_ref(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      OP_ALU_ADD: r = a + b;
      OP_ALU_SUB: r = a - b;
      OP_ALU_SLL: r = a << b[4:0];
      OP_ALU_SRL: r = a >> b[4:0];
      OP_ALU_SRA: r = $signed(a) >>> b[4:0];
      OP_ALU_SLT: r = ($signed(a) < $signed(b)) ? 1 : 0;
      OP_ALU_XOR: r = a ^ b;
      OP_ALU_OR:  r = a | b;
      OP_ALU_AND: r = a & b;
      default:    r = '0;
    endcase
    return r;
  endfunction

  // Reference decoder written from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] instr, input logic [W-1:0] rs1, input logic [W-1:0] rs2);
    exp_t e;
    int   f3  = int'(instr[14:12]);
    int   f7  = int'(instr[31:25]);
    bit   reg_form = (instr[6:0] == 7'h33);
    bit   imm_form = (instr[6:0] == 7'h13);
    bit   shift    = (f3 == 1) || (f3 == 5);
    bit   alt_ok   = (reg_form && f3 == 0) || f3 == 5;
    bit   f7_rule  = reg_form || shift;
    logic signed [W-1:0] imm = $signed(instr[31:20]);
    logic [5:0] names[8] = '{OP_ALU_ADD, OP_ALU_SLL, OP_ALU_SLT, OP_ALU_INV,
                             OP_ALU_XOR, OP_ALU_SRL, OP_ALU_OR, OP_ALU_AND};
    bit   legal = (reg_form || imm_form) && f3 != 3 &&
                  (!f7_rule || f7 == 0 || (f7 == 32 && alt_ok));
    e = '{op: OP_ALU_ADD, a: '0, b: '0, ill: 1'b1, chk_c: 1'b0, c: '0};
    if (legal) begin
      e.ill = 1'b0;
      e.a   = rs1;
      e.op  = names[f3];
      if (f7_rule && f7 == 32) e.op = (f3 == 0) ? OP_ALU_SUB : OP_ALU_SRA;
      if (reg_form)   e.b = rs2;
      else if (shift) e.b = W'(instr[24:20]);
      else            e.b = imm;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one instruction, hold until accepted, then queue its expected command.
  task automatic send(input logic [31:0] instr, input logic [W-1:0] r1, input logic [W-1:0] r2, input exp_t e);
    int  n = 0;
    bit  rdy;
    bit  done = 1'b0;
    in_valid   = 1'b1;
    in_instr   = instr;
    in_rs1_val = r1;
    in_rs2_val = r2;
    while (!done) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        sb.push_back(e);
        done = 1'b1;
      end else if (++n > 300) begin
        check("send_timeout", 64'(n), 0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    if (!rand_ready) out_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 0);
      end else begin
        e = sb[0];
        check("out_alu_op", 64'(out_alu_op), 64'(e.op));
        check("out_a", 64'(out_a), 64'(e.a));
        check("out_b", 64'(out_b), 64'(e.b));
        check("out_illegal", 64'(out_illegal), 64'(e.ill));
        if (e.chk_c) check("alu_o_c", 64'(alu_ref(out_alu_op, out_a, out_b)), 64'(e.c));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 0);
    check({tag, "_in_ready"}, 64'(in_ready), 1);
  endtask

  task automatic fill_both();
    out_ready = 1'b0;
    send(32'h00100093, 32'h11, 0, model(32'h00100093, 32'h11, 0));
    send(32'h00200093, 32'h22, 0, model(32'h00200093, 32'h22, 0));
    check("full_in_ready", 64'(in_ready), 0);
    in_valid = 1'b1;
    in_instr = 32'h00300093;
  endtask

  initial begin
    exp_t e;
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [6:0]  f7;
    int          r;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_rs1_val = '0; in_rs2_val = '0;
    #1;
    tick();
    check("rst_in_ready_low", 64'(in_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_alu_op", 64'(out_alu_op), 0);
    check("rst_out_a", 64'(out_a), 0);
    check("rst_out_b", 64'(out_b), 0);
    check("rst_out_illegal", 64'(out_illegal), 0);
    check("rst_in_ready", 64'(in_ready), 1);

    // addi x1,x0,5
    out_ready = 1'b1;
    send(32'h00500093, 0, 0, '{op: OP_ALU_ADD, a: 0, b: 5, ill: 0, chk_c: 1, c: 5});
    check("addi_next_cycle_valid", 64'(out_valid), 1);
    drain(20);
    // sub: 7 - 3
    send(32'h40208133, 7, 3, '{op: OP_ALU_SUB, a: 7, b: 3, ill: 0, chk_c: 1, c: 4});
    drain(20);
    // srai x1,x1,3
    send(32'h4030D093, 32'hfffffff0, 0,
         '{op: OP_ALU_SRA, a: 32'hfffffff0, b: 3, ill: 0, chk_c: 1, c: 32'hfffffffe});
    drain(20);
    // sltiu is not executable on this ALU
    send(32'h0010B093, 32'h1234, 32'h55, '{op: OP_ALU_ADD, a: 0, b: 0, ill: 1, chk_c: 0, c: 0});
    check("sltiu_valid", 64'(out_valid), 1);
    drain(20);

    // Three back-to-back inputs into a stalled output.
    out_ready = 1'b0;
    send(32'h00000033, 1, 0, model(32'h00000033, 1, 0));
    check("bp_in_ready_after_1", 64'(in_ready), 1);
    send(32'h00000033, 2, 0, model(32'h00000033, 2, 0));
    check("bp_in_ready_after_2", 64'(in_ready), 0);
    in_valid = 1'b1; in_instr = 32'h00000033; in_rs1_val = 3;
    tick();
    check("bp_in_ready_stalled", 64'(in_ready), 0);
    check("bp_out_valid_stalled", 64'(out_valid), 1);
    out_ready = 1'b1;
    send(32'h00000033, 3, 0, model(32'h00000033, 3, 0));
    drain(20);

    // Flush with both entries full and an input waiting.
    fill_both();
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check_idle("flush");
    // Flush drops an input presented on the same edge.
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00700093;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_idle("flush_drop");
    tick();
    check("flush_drop_later", 64'(out_valid), 0);

    // Reset with both entries full.
    fill_both();
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    #1;
    check_idle("midrst");
    check("midrst_out_alu_op", 64'(out_alu_op), 0);
    check("midrst_out_a", 64'(out_a), 0);
    tick();
    check("midrst_later", 64'(out_valid), 0);

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      opc = (r < 4) ? 7'h33 : (r < 8) ? 7'h13 : 7'($urandom);
      r = $urandom_range(0, 9);
      f7 = (r < 5) ? 7'h00 : (r < 8) ? 7'h20 : 7'($urandom);
      instr = $urandom;
      instr[6:0] = opc;
      instr[31:25] = f7;
      e = model(instr, W'($urandom), W'($urandom));
      send(instr, e.a, W'($urandom), '{op: 0, a: 0, b: 0, ill: 0, chk_c: 0, c: 0});
      void'(sb.pop_back());
      sb.push_back(model(instr, in_rs1_val, in_rs2_val));
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain(2000);
    rand_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_decode.md
ALU_DECODE -- requirements
Module: alu_decode

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, upstream instruction valid.
REQ-004 SHALL have port in_ready, output, 1, decoder can accept; registered, not combinationally dependent on out_ready.
REQ-005 SHALL have port in_instr, input, 32, RV32 instruction word.
REQ-006 SHALL have ports in_rs1_val and in_rs2_val, input, `DATA_WIDTH each, register-file operand values.
REQ-007 SHALL have port out_valid, output, 1, ALU command valid.
REQ-008 SHALL have port out_ready, input, 1, ALU-side stage accepts command.
REQ-009 SHALL have port out_alu_op, output, 6, ALU op code using the shared OP_ALU_* constants.
REQ-010 SHALL have ports out_a and out_b, output, `DATA_WIDTH each, ALU operands i_a and i_b.
REQ-011 SHALL have port out_illegal, output, 1, instruction not executable on the ALU.
REQ-012 SHALL have port flush, input, 1, discard all held commands.

Function
REQ-013 SHALL transfer an input when in_valid and in_ready are both high at a clock edge, and an output when out_valid and out_ready are both high.
REQ-014 SHALL hold two entries: an output register and one skid entry; in_ready SHALL be low exactly when the skid entry is occupied.
REQ-015 SHALL present an accepted instruction on the outputs the cycle after acceptance when the output register is empty or being drained that cycle.
REQ-016 SHALL, on output stall, place the accepted command in the skid entry and move it to the output register on the first output transfer; order SHALL be preserved and no command lost or duplicated.
REQ-017 SHALL keep out_alu_op, out_a, out_b and out_illegal stable while out_valid is high and out_ready is low.
REQ-018 SHALL decode opcode 0110011 (OP): funct3 000 -> ADD (funct7 0000000) or SUB (0100000); 001 SLL; 010 SLT; 100 XOR; 101 SRL (0000000) or SRA (0100000); 110 OR; 111 AND; out_a = rs1_val, out_b = rs2_val.
REQ-019 SHALL decode opcode 0010011 (OP-IMM) with the same funct3 mapping except that funct3 000 is always ADD; out_a = rs1_val; out_b = sign-extended instr[31:20], except for shifts, where out_b = zero-extended instr[24:20].
REQ-020 SHALL accept OP-IMM shifts only with instr[31:25] = 0000000 (SLLI, SRLI) or 0100000 (SRAI only).
REQ-021 SHALL flag out_illegal = 1 for the following cases: any other opcode, funct3 011 (no unsigned compare in the ALU), or any other funct7 value; such commands SHALL still flow through the handshake with out_alu_op = ADD, out_a = 0 and out_b = 0.
REQ-022 SHALL, when flush is high at a clock edge, empty both entries (out_valid = 0 and in_ready = 1 next cycle); any input presented that cycle SHALL be dropped; flush takes priority over all transfers.
REQ-023 SHALL never emit OP_ALU_INV; that code is reserved for other producers.

Reset
REQ-024 SHALL, while rst is high at a clock edge, clear both entries; the next cycle SHALL show out_valid = 0, out_alu_op = 0, out_a = 0, out_b = 0, out_illegal = 0 and in_ready = 1.
REQ-025 SHALL hold in_ready = 0 during every cycle in which rst is high; rst asserted mid-stall SHALL discard held commands without emitting them.

Structure
REQ-026 SHALL take `DATA_WIDTH and all OP_ALU_* codes from the shared ALU defines file; the RV32 opcode and funct constants (OP, OP-IMM, funct7 ALT = 0100000) SHALL be added to that same shared file.
REQ-027 SHALL place the combinational instruction-to-command mapping in one sub-module, alu_decode_comb; the top level SHALL hold only the two-entry buffer and handshake.

Verification
REQ-028 SHALL check the following: instr 0x00500093 (addi x1,x0,5), rs1_val = 0, out_ready = 1 -> next cycle out_valid = 1, op ADD, a = 0, b = 5, illegal = 0.
REQ-029 SHALL check the following: instr 0x40208133 (sub), rs1_val = 7, rs2_val = 3 -> op SUB, a = 7, b = 3; feeding a and b to alu gives o_c = 4.
REQ-030 SHALL check the following: instr 0x4030D093 (srai x1,x1,3), rs1_val = 0xfffffff0 -> op SRA, b = 3; alu o_c = 0xfffffffe.
REQ-031 SHALL check the following: instr 0x0010B093 (sltiu) -> out_valid = 1, out_illegal = 1, a = b = 0.
REQ-032 SHALL check the following: three back-to-back valid inputs with out_ready = 0 -> in_ready falls after the second acceptance; with out_ready then raised, outputs appear in order 1, 2, 3 with none lost.
REQ-033 SHALL check the following: both entries full, flush pulsed for one cycle -> next cycle out_valid = 0 and in_ready = 1; repeat with rst in place of flush and expect the same result.
